operand_fetch_unit: RTL

Parametrised successor to the datapath's register bank and operand muxes. It holds NUM_REGS registers of DATA_WIDTH bits, with one write port and one registered dual-operand read port. It adds write-to-read bypass, a per-register reservation scoreboard that stalls reads of in-flight destinations, and a valid/ready handshake toward the ALU stage. It sits between instruction decode (upstream) and the ALU (downstream); ALU results return through the write port.

---
 rtl/operand_fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/operand_fetch_unit.sv
// Register bank with registered dual-operand read port, write-to-read bypass,
// per-register reservation scoreboard and valid/ready handshake toward the ALU.
module operand_fetch_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          ZERO_R0    = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic [ADDR_WIDTH-1:0] WrAddr,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  ResvEn,
    input  logic [ADDR_WIDTH-1:0] ResvAddr,
    input  logic                  RdValid,
    output logic                  RdReady,
    input  logic [ADDR_WIDTH-1:0] RdAddrA,
    input  logic [ADDR_WIDTH-1:0] RdAddrB,
    output logic                  OpValid,
    input  logic                  OpReady,
    output logic [DATA_WIDTH-1:0] OpA,
    output logic [DATA_WIDTH-1:0] OpB,
    output logic [NUM_REGS-1:0]   Pending
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] val_a, val_b;
    logic                  blk_a, blk_b;
    logic                  hazard, rd_ready, accept;
    logic                  op_valid_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q;

    function automatic logic is_hardwired(input int unsigned idx);
        return ZERO_R0 && (idx == 0);
    endfunction

    // Out-of-range and hardwired-zero addresses never match any slot, so they
    // are dropped on write, read back as zero and can never be reserved.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (WrEn && WrAddr == ADDR_WIDTH'(i) && !is_hardwired(i)) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        val_a = '0;
        val_b = '0;
        blk_a = 1'b0;
        blk_b = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RdAddrA == ADDR_WIDTH'(i) && !is_hardwired(i)) begin
                val_a = wr_sel[i] ? WrData : regs_q[i];
                blk_a = pending_q[i] && !wr_sel[i];
            end
            if (RdAddrB == ADDR_WIDTH'(i) && !is_hardwired(i)) begin
                val_b = wr_sel[i] ? WrData : regs_q[i];
                blk_b = pending_q[i] && !wr_sel[i];
            end
        end
    end

    assign hazard   = blk_a || blk_b;
    assign rd_ready = (!op_valid_q || OpReady) && !hazard;
    assign accept   = RdValid && rd_ready;

    // A reservation on the accept edge overrides a same-edge write clear.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
                pending_d[i] = 1'b0;
            end
            if (accept && ResvEn && ResvAddr == ADDR_WIDTH'(i) && !is_hardwired(i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= WrData;
                end
            end
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else if (accept) begin
            op_valid_q <= 1'b1;
            op_a_q     <= val_a;
            op_b_q     <= val_b;
        end else if (OpReady) begin
            op_valid_q <= 1'b0;
        end
    end

    assign RdReady = rd_ready;
    assign OpValid = op_valid_q;
    assign OpA     = op_a_q;
    assign OpB     = op_b_q;
    assign Pending = pending_q;

endmodule
